data_memory_arbiter: RTL and testbench
======================================

DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 8, meaning the consecutive contended IDLE cycles before a loader grant is forced; legal range 1..255.
REQ-002 clk  input  1  the single clock; all state SHALL update on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 i_cpu_req  input  1  memory-stage access request.
REQ-005 i_cpu_we  input  1  memory-stage write enable.
REQ-006 i_cpu_addr  input  32  memory-stage byte address.
REQ-007 i_cpu_wdata  input  32  memory-stage write data.
REQ-008 o_cpu_stall  output  1  the memory-stage access was not performed this cycle.
REQ-009 o_cpu_rdata  output  32  memory-stage read data.
REQ-010 i_ldr_req  input  1  loader burst request.
REQ-011 i_ldr_we  input  1  burst direction (1 = write).
REQ-012 i_ldr_addr  input  32  burst base byte address.
REQ-013 i_ldr_len  input  4  burst beats minus one (1..16 beats).
REQ-014 i_ldr_wdata  input  32  write data for the current beat.
REQ-015 o_ldr_gnt  output  1  a beat is performed this cycle.
REQ-016 o_ldr_rdata  output  32  read data for the current beat.
REQ-017 o_ldr_done  output  1  single-cycle burst-complete pulse.
REQ-018 o_mem_we, o_mem_addr[31:0], o_mem_wdata[31:0]  output  data-memory port; i_mem_rdata[31:0] input, combinational read of o_mem_addr; the memory writes at posedge when o_mem_we is high.

Function
REQ-019 The FSM SHALL have states IDLE, BURST and DONE.
REQ-020 In IDLE and DONE, the memory port SHALL carry the memory-stage request:
- o_mem_addr = i_cpu_addr
- o_mem_wdata = i_cpu_wdata
- o_mem_we = i_cpu_req & i_cpu_we
- o_cpu_stall = 0
REQ-021 In IDLE, a grant SHALL occur when i_ldr_req & (!i_cpu_req | wait_cnt == STARVE_LIMIT).
- On grant: next state BURST.
- Latch base = i_ldr_addr, we = i_ldr_we, len = i_ldr_len.
- Clear beat counter and wait_cnt.
REQ-022 wait_cnt SHALL:
- increment in IDLE when i_ldr_req & i_cpu_req and no grant occurs;
- clear when i_ldr_req = 0;
- saturate at STARVE_LIMIT.
REQ-023 In BURST, the memory port SHALL carry the current beat:
- o_mem_addr = base + beat*4, modulo 2^32; low two bits of base pass through unchanged.
- o_mem_we = latched we; o_mem_wdata = i_ldr_wdata.
- o_ldr_gnt = 1; o_ldr_rdata = i_mem_rdata.
- beat increments each cycle.
REQ-024 In BURST, o_cpu_stall SHALL equal i_cpu_req, and the memory-stage access SHALL NOT reach memory.
REQ-025 BURST SHALL last exactly len+1 cycles; when beat == len, next state SHALL be DONE.
REQ-026 DONE SHALL last one cycle with o_ldr_done = 1, then go to IDLE; no grant SHALL be decided in DONE.
REQ-027 Changes to i_ldr_addr, i_ldr_we or i_ldr_len during BURST SHALL be ignored.
REQ-028 o_cpu_rdata SHALL equal i_mem_rdata at all times; it is valid only when o_cpu_stall = 0.
REQ-029 Outside BURST: o_ldr_gnt = 0 and o_ldr_rdata = 0. Outside DONE: o_ldr_done = 0.
REQ-030 A loader holding i_ldr_req high after DONE SHALL be re-arbitrated as a new burst from IDLE.

Reset
REQ-031 While rst = 1, regardless of current state or mid-burst:
- o_mem_we = 0, o_ldr_gnt = 0, o_ldr_done = 0, o_cpu_stall = i_cpu_req.
- Next state IDLE; wait_cnt, beat, base, we and len cleared to 0.
REQ-032 A burst interrupted by reset SHALL NOT produce o_ldr_done and SHALL NOT resume.

Verification
REQ-033 CPU only: i_cpu_req=1, we=1, addr=0x10, wdata=0xDEADBEEF -> o_mem_we=1, o_mem_addr=0x10, o_cpu_stall=0; read back 0x10 next cycle -> o_cpu_rdata=0xDEADBEEF.
REQ-034 Uncontended burst: ldr_req, we=1, addr=0x100, len=3, cpu idle -> gnt high 4 cycles at 0x100/104/108/10C, done pulse 1 cycle after, then IDLE.
REQ-035 Contention and starvation, STARVE_LIMIT=8, both requesting continuously -> CPU served 9 IDLE cycles (no stall), then burst granted, o_cpu_stall=1 for len+1 cycles and 0 in DONE.
REQ-036 Address wrap: base=0xFFFFFFFC, len=1 -> beat addresses 0xFFFFFFFC then 0x00000000.
REQ-037 Reset mid-burst: rst after beat 2 of len=7 -> gnt=0 and mem_we=0 the same cycle, no done pulse, IDLE with wait_cnt=0.
REQ-038 Back-to-back bursts: ldr_req held, cpu idle -> BURST, DONE, IDLE, BURST with exactly one IDLE cycle between the two bursts.

Source files
------------

// File: rtl/data_memory_arbiter_if.sv
// Bus bundle between the data-memory arbiter and its three neighbours:
// the pipeline memory stage (cpu), the burst loader (ldr) and the
// single-port data memory (mem).
//
// Ports carried:
//   cpu : i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata -> o_cpu_stall, o_cpu_rdata
//   ldr : i_ldr_req, i_ldr_we, i_ldr_addr, i_ldr_len, i_ldr_wdata
//         -> o_ldr_gnt, o_ldr_rdata, o_ldr_done
//   mem : o_mem_we, o_mem_addr, o_mem_wdata -> i_mem_rdata (combinational read)
//
// Modport slave is taken by the arbiter; modport master by whatever drives
// the arbiter's requests and models the memory.
interface data_memory_arbiter_if;
  logic        i_cpu_req;
  logic        i_cpu_we;
  logic [31:0] i_cpu_addr;
  logic [31:0] i_cpu_wdata;
  logic        o_cpu_stall;
  logic [31:0] o_cpu_rdata;

  logic        i_ldr_req;
  logic        i_ldr_we;
  logic [31:0] i_ldr_addr;
  logic [3:0]  i_ldr_len;
  logic [31:0] i_ldr_wdata;
  logic        o_ldr_gnt;
  logic [31:0] o_ldr_rdata;
  logic        o_ldr_done;

  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;

  modport slave (
    input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    output o_cpu_stall, o_cpu_rdata,
    input  i_ldr_req, i_ldr_we, i_ldr_addr, i_ldr_len, i_ldr_wdata,
    output o_ldr_gnt, o_ldr_rdata, o_ldr_done,
    output o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_rdata
  );

  modport master (
    output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    input  o_cpu_stall, o_cpu_rdata,
    output i_ldr_req, i_ldr_we, i_ldr_addr, i_ldr_len, i_ldr_wdata,
    input  o_ldr_gnt, o_ldr_rdata, o_ldr_done,
    input  o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_rdata
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// Data-memory arbiter: shares one single-port data memory between the
// pipeline memory stage (single accesses, highest priority) and a burst
// loader (1..16 beat bursts). A loader kept waiting by a busy memory stage
// is forced in after STARVE_LIMIT contended idle cycles. While a burst runs,
// the memory stage is stalled whenever it requests.
//
// Ports:
//   clk  : clock, all state updates on its rising edge
//   rst  : synchronous active-high reset
//   bus  : data_memory_arbiter_if.slave (cpu, loader and memory signals)
// Parameter:
//   STARVE_LIMIT : contended idle cycles before a loader grant is forced (1..255)
module data_memory_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  data_memory_arbiter_if.slave  bus
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DONE
  } state_t;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [3:0]  beat;
  logic [3:0]  len;
  logic [31:0] base;
  logic        we;

  logic        grant;
  logic [31:0] beat_addr;

  // The memory stage wins an idle cycle unless the loader has waited long enough.
  assign grant = (state == IDLE) && bus.i_ldr_req &&
                 (!bus.i_cpu_req || (wait_cnt == LIMIT));

  // Word step on top of the base keeps the base's low two bits untouched
  // and wraps naturally at 2^32.
  assign beat_addr = base + {26'd0, beat, 2'b00};

  // Arbitration state, burst bookkeeping and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
      beat     <= 4'd0;
      len      <= 4'd0;
      base     <= 32'd0;
      we       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state    <= BURST;
            base     <= bus.i_ldr_addr;
            we       <= bus.i_ldr_we;
            len      <= bus.i_ldr_len;
            beat     <= 4'd0;
            wait_cnt <= 8'd0;
          end else if (!bus.i_ldr_req) begin
            wait_cnt <= 8'd0;
          end else if (wait_cnt != LIMIT) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        BURST: begin
          if (beat == len) begin
            state <= DONE;
            beat  <= 4'd0;
          end else begin
            beat <= beat + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Memory port steering and handshake outputs. Reset overrides the
  // state so that an interrupted burst cannot write or report completion.
  always_comb begin
    bus.o_mem_addr  = bus.i_cpu_addr;
    bus.o_mem_wdata = bus.i_cpu_wdata;
    bus.o_mem_we    = bus.i_cpu_req & bus.i_cpu_we;
    bus.o_cpu_stall = 1'b0;
    bus.o_ldr_gnt   = 1'b0;
    bus.o_ldr_rdata = 32'd0;
    bus.o_ldr_done  = 1'b0;
    if (rst) begin
      bus.o_mem_we    = 1'b0;
      bus.o_cpu_stall = bus.i_cpu_req;
    end else if (state == BURST) begin
      bus.o_mem_addr  = beat_addr;
      bus.o_mem_wdata = bus.i_ldr_wdata;
      bus.o_mem_we    = we;
      bus.o_cpu_stall = bus.i_cpu_req;
      bus.o_ldr_gnt   = 1'b1;
      bus.o_ldr_rdata = bus.i_mem_rdata;
    end else if (state == DONE) begin
      bus.o_ldr_done = 1'b1;
    end
  end

  assign bus.o_cpu_rdata = bus.i_mem_rdata;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter. Directed scenarios followed by
// a randomized phase; expected outputs come from a transaction-level model
// (a queue of pending beat addresses, a done flag and a wait count).
module tb_data_memory_arbiter;

  localparam int LIMIT = 8;

  logic clk;
  logic rst;
  data_memory_arbiter_if bus ();

  data_memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: 1024 words, aliased on address bits [11:2].
  logic [31:0] mem [1024];
  assign bus.i_mem_rdata = mem[bus.o_mem_addr[11:2]];

  int total = 0;
  int bad   = 0;

  // Model state
  logic [31:0] beatQ[$];
  bit          burstWe;
  bit          doneFlag;
  int          waitCnt;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit rstV, input bit cReq, input bit cWe,
                               input logic [31:0] cAddr, input logic [31:0] cWd,
                               input bit lReq, input bit lWe, input logic [31:0] lAddr,
                               input logic [3:0] lLen, input logic [31:0] lWd);
    @(negedge clk);
    rst             = rstV;
    bus.i_cpu_req   = cReq;
    bus.i_cpu_we    = cWe;
    bus.i_cpu_addr  = cAddr;
    bus.i_cpu_wdata = cWd;
    bus.i_ldr_req   = lReq;
    bus.i_ldr_we    = lWe;
    bus.i_ldr_addr  = lAddr;
    bus.i_ldr_len   = lLen;
    bus.i_ldr_wdata = lWd;
    #1;
  endtask

  task automatic checkOutput(input string tag);
    bit          eWe, eGnt, eDone, eStall;
    logic [31:0] eAddr, eWd, eLdrRd;
    eGnt = 1'b0; eDone = 1'b0; eLdrRd = 32'd0;
    eAddr = bus.i_cpu_addr; eWd = bus.i_cpu_wdata;
    if (rst) begin
      eWe = 1'b0; eStall = bus.i_cpu_req;
    end else if (beatQ.size() > 0) begin
      eGnt = 1'b1; eAddr = beatQ[0]; eWe = burstWe; eWd = bus.i_ldr_wdata;
      eStall = bus.i_cpu_req; eLdrRd = mem[eAddr[11:2]];
    end else begin
      eWe = bus.i_cpu_req & bus.i_cpu_we; eStall = 1'b0; eDone = doneFlag;
    end
    checkVal({tag, ".mem_we"}, 32'(bus.o_mem_we), 32'(eWe));
    checkVal({tag, ".ldr_gnt"}, 32'(bus.o_ldr_gnt), 32'(eGnt));
    checkVal({tag, ".ldr_done"}, 32'(bus.o_ldr_done), 32'(eDone));
    checkVal({tag, ".cpu_stall"}, 32'(bus.o_cpu_stall), 32'(eStall));
    if (!rst) begin
      checkVal({tag, ".mem_addr"}, bus.o_mem_addr, eAddr);
      checkVal({tag, ".mem_wdata"}, bus.o_mem_wdata, eWd);
      checkVal({tag, ".ldr_rdata"}, bus.o_ldr_rdata, eLdrRd);
      checkVal({tag, ".cpu_rdata"}, bus.o_cpu_rdata, mem[eAddr[11:2]]);
    end
  endtask

  // Close the cycle: memory write at the edge, then advance the model.
  task automatic commitCycle();
    bit          wWe;
    logic [31:0] wAddr, wData;
    wWe = bus.o_mem_we; wAddr = bus.o_mem_addr; wData = bus.o_mem_wdata;
    @(posedge clk);
    if (wWe) mem[wAddr[11:2]] = wData;
    if (rst) begin
      beatQ.delete(); doneFlag = 1'b0; waitCnt = 0;
    end else if (beatQ.size() > 0) begin
      void'(beatQ.pop_front());
      if (beatQ.size() == 0) doneFlag = 1'b1;
    end else if (doneFlag) begin
      doneFlag = 1'b0;
    end else if (bus.i_ldr_req && (!bus.i_cpu_req || waitCnt >= LIMIT)) begin
      for (int k = 0; k <= int'(bus.i_ldr_len); k++)
        beatQ.push_back(bus.i_ldr_addr + 32'(k * 4));
      burstWe = bus.i_ldr_we;
      waitCnt = 0;
    end else if (!bus.i_ldr_req) begin
      waitCnt = 0;
    end else if (waitCnt < LIMIT) begin
      waitCnt++;
    end
  endtask

  task automatic step(input string tag, input bit rstV, input bit cReq, input bit cWe,
                      input logic [31:0] cAddr, input logic [31:0] cWd,
                      input bit lReq, input bit lWe, input logic [31:0] lAddr,
                      input logic [3:0] lLen, input logic [31:0] lWd);
    applyStimulus(rstV, cReq, cWe, cAddr, cWd, lReq, lWe, lAddr, lLen, lWd);
    checkOutput(tag);
    commitCycle();
  endtask

  initial begin
    bit          rr, cq, cw, lq, lw;
    logic [31:0] ca, cd, la, ld;
    logic [3:0]  ll;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    beatQ.delete(); burstWe = 1'b0; doneFlag = 1'b0; waitCnt = 0;
    rst = 1'b1;
    bus.i_cpu_req = 1'b0; bus.i_cpu_we = 1'b0; bus.i_cpu_addr = 32'd0; bus.i_cpu_wdata = 32'd0;
    bus.i_ldr_req = 1'b0; bus.i_ldr_we = 1'b0; bus.i_ldr_addr = 32'd0; bus.i_ldr_len = 4'd0;
    bus.i_ldr_wdata = 32'd0;

    // Reset state
    step("reset0", 1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 4'd0, 32'h0);
    step("reset1", 1, 1, 1, 32'h40, 32'h1, 1, 1, 32'h200, 4'd2, 32'h2);

    // CPU write then read back
    step("cpu_wr", 0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 4'd0, 32'h0);
    applyStimulus(0, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 4'd0, 32'h0);
    checkOutput("cpu_rd");
    checkVal("cpu_rd.const", bus.o_cpu_rdata, 32'hDEADBEEF);
    commitCycle();

    // Uncontended 4-beat write burst, loader drops request after grant
    step("b4.req", 0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h100, 4'd3, 32'hA0);
    for (int i = 0; i < 4; i++)
      step("b4.beat", 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h999, 4'd9, 32'hA1 + 32'(i));
    step("b4.done", 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 4'd0, 32'h0);
    step("b4.idle", 0, 1, 0, 32'h104, 32'h0, 0, 0, 32'h0, 4'd0, 32'h0);

    // Contention: starvation forces grant after LIMIT+1 cpu-served cycles
    for (int i = 0; i < LIMIT + 1 + 3 + 2; i++)
      step("starve", 0, 1, 0, 32'h20 + 32'(i * 4), 32'h0, (i < LIMIT + 1), 0, 32'h300, 4'd2, 32'h0);

    // Address wrap
    step("wrap.req", 0, 0, 0, 32'h0, 32'h0, 1, 0, 32'hFFFFFFFC, 4'd1, 32'h0);
    for (int i = 0; i < 3; i++)
      step("wrap", 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 4'd0, 32'h0);

    // Reset after beat 2 of an 8-beat burst, then contention from scratch
    step("rstmid.req", 0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h400, 4'd7, 32'h0);
    for (int i = 0; i < 3; i++)
      step("rstmid.beat", 0, 1, 1, 32'h50, 32'h55, 0, 0, 32'h0, 4'd0, 32'hB0 + 32'(i));
    step("rstmid.rst", 1, 1, 1, 32'h50, 32'h55, 0, 1, 32'h0, 4'd0, 32'hBB);
    for (int i = 0; i < LIMIT + 4; i++)
      step("rstmid.after", 0, 1, 1, 32'h60, 32'h66 + 32'(i), 1, 0, 32'h500, 4'd0, 32'h0);
    step("rstmid.clr", 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 4'd0, 32'h0);
    step("rstmid.clr2", 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 4'd0, 32'h0);

    // Back-to-back bursts with loader request held
    for (int i = 0; i < 12; i++)
      step("b2b", 0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h600, 4'd2, 32'hC0 + 32'(i));

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rr = ($urandom_range(0, 99) < 2);
      cq = ($urandom_range(0, 99) < 75);
      cw = $urandom_range(0, 1);
      ca = $urandom & 32'h0000_0FFF;
      cd = $urandom;
      lq = ($urandom_range(0, 99) < 40);
      lw = $urandom_range(0, 1);
      la = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_0FFF);
      ll = 4'($urandom);
      ld = $urandom;
      step("rand", rr, cq, cw, ca, cd, lq, lw, la, ll, ld);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
